// File: rtl/tt_um_out_buffer.sv
// Output stage of the ternary matrix-vector multiplier: requantizes per-row dot products
// into a two-bank frame buffer and streams completed frames out one element per handshake.
module tt_um_out_buffer #(
    parameter int OutLen   = 8,
    parameter int InWidth  = 12,
    parameter int BitWidth = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [$clog2(OutLen)-1:0]  in_row,
    input  logic [InWidth-1:0]         in_data,
    input  logic [3:0]                 cfg_shift,
    input  logic                       cfg_relu,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BitWidth-1:0]        out_data,
    output logic                       out_last,
    output logic                       overflow,
    output logic                       seq_err,
    output logic                       busy,
    output logic                       dbg_state
);
    localparam int RowW = $clog2(OutLen);
    localparam logic [RowW-1:0] LastRow = RowW'(OutLen - 1);
    localparam logic signed [InWidth-1:0] SatMax = InWidth'((1 << (BitWidth - 1)) - 1);
    localparam logic signed [InWidth-1:0] SatMin = InWidth'(-(1 << (BitWidth - 1)));

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t              state_q, state_d;
    logic [RowW-1:0]     exp_row_q, exp_row_d;
    logic [RowW-1:0]     rd_idx_q;
    logic                wr_bank_q, rd_bank_q;
    logic [1:0]          full_q, full_d;
    logic                overflow_q, seq_err_q;
    logic [BitWidth-1:0] mem_q [2][OutLen];

    logic                       wr_en, frame_done, set_ovf, set_seq;
    logic                       rd_hs, rd_done, bank_free;
    logic signed [InWidth-1:0]  shifted, relu_v;
    logic [BitWidth-1:0]        rq_val;

    always_comb begin
        shifted = $signed(in_data) >>> cfg_shift;
        relu_v  = shifted;
        rq_val  = shifted[BitWidth-1:0];
        if (cfg_relu && shifted < 0) relu_v = '0;
        if (relu_v > SatMax)      rq_val = SatMax[BitWidth-1:0];
        else if (relu_v < SatMin) rq_val = SatMin[BitWidth-1:0];
        else                      rq_val = relu_v[BitWidth-1:0];
    end

    assign rd_hs   = full_q[rd_bank_q] & out_ready;
    assign rd_done = rd_hs & (rd_idx_q == LastRow);
    // The write bank counts as free when its final element leaves this very cycle.
    assign bank_free = !full_q[wr_bank_q] | (rd_done & (rd_bank_q == wr_bank_q));

    always_comb begin
        state_d    = state_q;
        exp_row_d  = exp_row_q;
        wr_en      = 1'b0;
        frame_done = 1'b0;
        set_ovf    = 1'b0;
        set_seq    = 1'b0;
        if (in_valid) begin
            if (state_q == CAPTURE && in_row == exp_row_q) begin
                wr_en = 1'b1;
                if (in_row == LastRow) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end else begin
                    exp_row_d = exp_row_q + RowW'(1);
                end
            end else begin
                // Partial frame is abandoned; a row 0 may restart in the same cycle.
                if (state_q == CAPTURE || in_row != '0) set_seq = 1'b1;
                state_d = IDLE;
                if (in_row == '0) begin
                    if (bank_free) begin
                        wr_en     = 1'b1;
                        state_d   = CAPTURE;
                        exp_row_d = RowW'(1);
                    end else begin
                        set_ovf = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        full_d = full_q;
        if (rd_done)    full_d[rd_bank_q] = 1'b0;
        if (frame_done) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            exp_row_q  <= '0;
            rd_idx_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= '0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_row_q  <= exp_row_d;
            full_q     <= full_d;
            overflow_q <= overflow_q | set_ovf;
            seq_err_q  <= seq_err_q | set_seq;
            if (frame_done) wr_bank_q <= ~wr_bank_q;
            if (rd_done) begin
                rd_bank_q <= ~rd_bank_q;
                rd_idx_q  <= '0;
            end else if (rd_hs) begin
                rd_idx_q <= rd_idx_q + RowW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < OutLen; r++)
                    mem_q[b][r] <= '0;
        end else if (wr_en) begin
            mem_q[wr_bank_q][in_row] <= rq_val;
        end
    end

    assign out_valid = full_q[rd_bank_q];
    assign out_data  = mem_q[rd_bank_q][rd_idx_q];
    assign out_last  = out_valid & (rd_idx_q == LastRow);
    assign overflow  = overflow_q;
    assign seq_err   = seq_err_q;
    assign busy      = (state_q == CAPTURE) | full_q[0] | full_q[1];
    assign dbg_state = (state_q == CAPTURE);
endmodule

// File: tb/tb_tt_um_out_buffer.sv
// Bench for tt_um_out_buffer: directed scenarios plus random traffic, checked every cycle
// against a frame-queue reference model.
module tb_tt_um_out_buffer;
    localparam int OutLen = 8;
    localparam int InW    = 12;
    localparam int BW     = 8;
    localparam int RW     = $clog2(OutLen);

    logic          clk, rst, in_valid, cfg_relu, out_ready;
    logic [RW-1:0] in_row;
    logic [InW-1:0] in_data;
    logic [3:0]    cfg_shift;
    logic          out_valid, out_last, overflow, seq_err, busy, dbg_state;
    logic [BW-1:0] out_data;

    tt_um_out_buffer #(.OutLen(OutLen), .InWidth(InW), .BitWidth(BW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_row(in_row), .in_data(in_data),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .overflow(overflow), .seq_err(seq_err), .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: completed frames live in one flat queue of expected elements
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] m_part[OutLen];
    int m_nfull = 0, m_rdpos = 0, m_exp = 0;
    bit m_cap = 0, m_ovf = 0, m_seq = 0, m_zero = 0, m_known = 0;

    function automatic logic [BW-1:0] rq(input int d, input int sh, input bit rl);
        int p, q;
        p = 1 << sh;
        q = d / p;
        if (d < 0 && (d % p) != 0) q = q - 1;   // floor division
        if (rl && q < 0) q = 0;
        if (q > (1 << (BW - 1)) - 1) q = (1 << (BW - 1)) - 1;
        if (q < -(1 << (BW - 1))) q = -(1 << (BW - 1));
        return q[BW-1:0];
    endfunction

    task automatic model_step(input bit r, input bit v, input int row, input int d,
                              input int sh, input bit rl, input bit rdy);
        bit hs, done, free;
        if (r) begin
            exp_q.delete();
            m_nfull = 0; m_rdpos = 0; m_cap = 0; m_exp = 0;
            m_ovf = 0; m_seq = 0; m_zero = 1; m_known = 1;
            return;
        end
        m_zero = 0;
        hs   = (m_nfull > 0) && rdy;
        done = hs && (m_rdpos == OutLen - 1);
        free = (m_nfull < 2) || done;
        if (hs) begin
            void'(exp_q.pop_front());
            m_rdpos = done ? 0 : m_rdpos + 1;
            if (done) m_nfull--;
        end
        if (v) begin
            if (m_cap && row == m_exp) begin
                m_part[row] = rq(d, sh, rl);
                if (row == OutLen - 1) begin
                    for (int i = 0; i < OutLen; i++) exp_q.push_back(m_part[i]);
                    m_nfull++;
                    m_cap = 0;
                end else begin
                    m_exp++;
                end
            end else begin
                if (m_cap || row != 0) m_seq = 1;
                m_cap = 0;
                if (row == 0) begin
                    if (free) begin
                        m_part[0] = rq(d, sh, rl);
                        m_cap = 1;
                        m_exp = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
        end
    endtask

    // driver
    bit g_rdy = 1;
    int g_sh = 0;
    bit g_rl = 0;

    task automatic cycle(input bit r, input bit v, input int row, input int d);
        rst = r; in_valid = v; in_row = RW'(row); in_data = InW'(d);
        cfg_shift = 4'(g_sh); cfg_relu = g_rl; out_ready = g_rdy;
        @(negedge clk);
        if (m_known) begin
            check("out_valid", 32'(out_valid), 32'(m_nfull > 0));
            if (m_nfull > 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
            if (m_zero) check("rst_data", 32'(out_data), 32'd0);
            check("out_last", 32'(out_last), 32'((m_nfull > 0) && (m_rdpos == OutLen - 1)));
            check("busy", 32'(busy), 32'(m_cap || m_nfull > 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("seq_err", 32'(seq_err), 32'(m_seq));
            check("state", 32'(dbg_state), 32'(m_cap));
        end
        model_step(r, v, row, d, g_sh, g_rl, g_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic send_frame(input int base, input int stp);
        for (int r = 0; r < OutLen; r++) cycle(0, 1, r, base + stp * r);
    endtask

    int rq_data[OutLen] = '{2047, -2048, -100, 200, -7, 1000, -1000, 55};
    int rq_sh[OutLen]   = '{0, 0, 0, 2, 1, 3, 4, 0};
    bit rq_rl[OutLen]   = '{0, 0, 1, 0, 0, 0, 1, 1};
    int seq_rows[4]     = '{0, 1, 2, 5};
    bit rdy_pat[4]      = '{1, 0, 0, 1};

    initial begin
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);

        // single frame, one element per cycle on the way out
        g_rdy = 1;
        send_frame(10, 10);
        idle(10);

        // requantization corner cases, cfg varying per row
        for (int r = 0; r < OutLen; r++) begin
            g_sh = rq_sh[r]; g_rl = rq_rl[r];
            cycle(0, 1, r, rq_data[r]);
        end
        g_sh = 0; g_rl = 0;
        idle(10);

        // both banks filled, third frame dropped, then drain 16 elements
        g_rdy = 0;
        send_frame(1, 3);
        send_frame(-50, 7);
        send_frame(100, 1);
        idle(3);
        g_rdy = 1;
        idle(20);
        cycle(1, 0, 0, 0);

        // a bank freed by the final read handshake is reusable in the same cycle
        g_rdy = 0;
        send_frame(5, 2);
        send_frame(-5, -2);
        idle(2);
        g_rdy = 1;
        idle(OutLen - 1);
        send_frame(30, 4);
        idle(20);
        cycle(1, 0, 0, 0);

        // out-of-order row abandons the frame; the next full frame is normal
        for (int i = 0; i < 4; i++) cycle(0, 1, seq_rows[i], 40 + i);
        idle(3);
        send_frame(-20, 5);
        idle(12);

        // backpressure, then reset mid-drain
        g_rdy = 0;
        send_frame(60, -9);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            g_rdy = rdy_pat[i];
            idle(1);
        end
        g_rdy = 1;
        idle(1);
        cycle(1, 0, 0, 0);
        idle(3);

        // random traffic
        begin
            int nr = 0;
            for (int i = 0; i < 1500; i++) begin
                int row;
                bit v;
                g_rdy = ($urandom_range(0, 3) != 0);
                g_sh  = $urandom_range(0, 15);
                g_rl  = ($urandom_range(0, 3) == 0);
                v     = ($urandom_range(0, 3) != 0);
                row   = ($urandom_range(0, 15) == 0) ? $urandom_range(0, OutLen - 1) : nr;
                if (v) nr = (row + 1) % OutLen;
                if ($urandom_range(0, 299) == 0) cycle(1, 0, 0, 0);
                else cycle(0, v, row, int'($urandom_range(0, 4095)) - 2048);
            end
        end
        g_rdy = 1;
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tt_um_out_buffer.md
Name: tt_um_out_buffer

Overview:
- Downstream stage of the ternary matrix-vector multiplier.
- Captures the per-row dot-product results the multiplier emits one row per cycle (rows 0..OutLen-1).
- Requantizes each result: arithmetic shift, optional ReLU, signed saturation to BitWidth.
- Holds up to two complete output frames in a double buffer and streams them out byte-serially on a valid/ready handshake, so the multiplier never stalls on a slow consumer unless both banks are occupied.

Parameters:
- OutLen, 8: rows per output frame; power of two, ≥2.
- InWidth, 12: width of signed dot-product input.
- BitWidth, 8: width of signed requantized output.

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_row/in_data carry a row result this cycle
- in_row  input  $clog2(OutLen)  row index of in_data
- in_data  input  InWidth  signed dot-product result
- cfg_shift  input  4  arithmetic right-shift amount, 0..15
- cfg_relu  input  1  1 = clamp negatives to 0
- out_valid  output  1  out_data holds a valid element
- out_ready  input  1  consumer accepts element when out_valid&out_ready
- out_data  output  BitWidth  requantized element, signed
- out_last  output  1  current element is row OutLen-1 of its frame
- overflow  output  1  sticky: a frame was dropped because both banks were full
- seq_err  output  1  sticky: row arrived out of order
- busy  output  1  a frame is partially captured or any bank is full

Behaviour:
- Reset (rst=1 at an edge): outputs are all 0. Bank full flags=0, wr_bank=rd_bank=0, expected_row=0, rd_idx=0, capturing=0, sticky flags=0. Reset mid-frame or mid-drain discards everything with no partial output.
- Requantize at capture, using cfg sampled in the same cycle:
  - s = in_data >>> cfg_shift, sign-extended.
  - If cfg_relu and s<0, s=0.
  - Saturate to [-2^(BitWidth-1), 2^(BitWidth-1)-1]; default range is [-128, 127].
- Capture FSM, states IDLE and CAPTURE:
  - IDLE: in_valid with in_row=0 starts a frame.
    - If bank[wr_bank] is free, or is being freed this same cycle by the final read handshake: write row 0, go to CAPTURE, expected_row=1.
    - Otherwise: set overflow, stay IDLE, and ignore rows until the next row 0.
  - IDLE: in_valid with in_row≠0 sets seq_err and is ignored.
  - CAPTURE: in_valid with in_row=expected_row writes the element and increments expected_row.
    - If in_row=OutLen-1: set full[wr_bank], toggle wr_bank, go to IDLE.
  - CAPTURE: in_valid with in_row≠expected_row sets seq_err and discards the partial frame (bank stays free).
    - If in_row=0, the mismatched row starts a new frame in the same cycle under the IDLE rules.
    - Otherwise go to IDLE.
  - in_valid=0 holds state; there is no timeout.
- Read side:
  - out_valid = full[rd_bank]; out_data = bank[rd_bank][rd_idx], driven straight from registers.
  - out_last = out_valid & (rd_idx=OutLen-1).
  - On handshake rd_idx increments. On handshake with out_last: clear full[rd_bank], toggle rd_bank, rd_idx=0.
  - out_data holds stable while out_valid & !out_ready.
- Latency: the last row captured at edge N gives out_valid=1 in the cycle after edge N, i.e. 1 cycle.
  - Back-to-back drain with out_ready=1: one element per cycle, OutLen cycles per frame.
  - A second full bank presents its element 0 on the cycle immediately after out_last, with no bubble.
- Simultaneous capture-complete and drain-complete on different banks: both take effect; flags are independent.
- Sticky flags clear only on rst.
- busy = (state=CAPTURE) | full[0] | full[1].

Test Plan:
- Single frame: rows 0..7 data 10,20,..,80 on consecutive cycles, shift=0, relu=0, out_ready=1 → out_valid rises the cycle after row 7; out_data 10..80 over 8 cycles; out_last only with 80; busy=0 afterwards.
- Requantize: in_data=+2047 (shift 0) → 127; in_data=-2048 → -128; in_data=-100 with relu=1 → 0; in_data=200 with shift=2 → 50; in_data=-7 with shift=1 → -4.
- Double buffer and overflow: out_ready=0, three frames sent → first two held and busy=1; third dropped and overflow=1. Raise out_ready → 16 elements from frames 1 then 2, out_last on elements 8 and 16.
- Same-cycle free: out_ready=0 with both banks full; the cycle frame 1's out_last handshakes, frame 3 row 0 arrives → accepted, overflow stays 0.
- Sequence error: rows 0,1,2,5 → seq_err=1, no output. Then rows 0..7 → one normal frame emitted.
- Backpressure plus reset: out_ready toggled 1,0,0,1 → out_data stable across stalls. Assert rst mid-drain → out_valid=0, overflow=0, seq_err=0, busy=0 on the next cycle.
